// File: rtl/ai_accel_pkg.sv
// rtl/ai_accel_pkg.sv - shared types and register map constants for the AI accelerator
package ai_accel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    localparam logic [1:0] PFX_OP = 2'b00;
    localparam logic [1:0] PFX_A  = 2'b01;
    localparam logic [1:0] PFX_B  = 2'b10;
    localparam logic [1:0] PFX_C  = 2'b11;

    localparam logic [3:0] OP_CODE = 4'd0;
    localparam logic [3:0] OP_GO   = 4'd5;

    localparam logic [31:0] GO_VALUE = 32'hFFFF_FFFF;

    // True when the address selects the operation-code register of the op block.
    function automatic logic is_op_code(input logic [1:0] pfx, input logic [3:0] idx);
        return (pfx == PFX_OP) && (idx == OP_CODE);
    endfunction

endpackage

// File: rtl/ai_accel_wb_arbiter_timer.sv
// rtl/ai_accel_wb_arbiter_timer.sv - saturating idle counter that force-releases a stale job lock
module ai_lock_timer #(
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic lock_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LOCK_TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: zero when unlocked or cleared, otherwise count up and stick at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (!lock_i || clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = lock_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/ai_accel_wb_arbiter.sv
// rtl/ai_accel_wb_arbiter.sv - two-master Wishbone arbiter with job lock in front of the accelerator
module ai_accel_wb_arbiter
    import ai_accel_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic              m0_we_i,
    input  logic [DATA_W-1:0] m0_data_i,
    input  logic              m0_stb_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic              m1_we_i,
    input  logic [DATA_W-1:0] m1_data_i,
    input  logic              m1_stb_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic              s_we_o,
    output logic [DATA_W-1:0] s_data_o,
    output logic              s_stb_o,
    input  logic              s_ack_i,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              lock_valid_o,
    output logic              lock_owner_o
);

    wb_state_e         state_q;
    logic              last_grant_q;
    logic              lock_valid_q;
    logic              lock_owner_q;
    logic [ADDR_W-1:0] s_addr_q;
    logic              s_we_q;
    logic [DATA_W-1:0] s_data_q;
    logic              s_stb_q;
    logic              m0_ack_q;
    logic              m1_ack_q;
    logic [DATA_W-1:0] m0_data_q;
    logic [DATA_W-1:0] m1_data_q;

    logic elig0;
    logic elig1;
    logic grant_valid;
    logic grant_idx;
    logic op_hit;
    logic timer_clear;
    logic lock_expire;

    // Eligibility and round-robin pick; a held lock masks the non-owner.
    always_comb begin
        elig0       = m0_stb_i && (!lock_valid_q || !lock_owner_q);
        elig1       = m1_stb_i && (!lock_valid_q ||  lock_owner_q);
        grant_valid = elig0 || elig1;
        if (elig0 && elig1) begin
            grant_idx = ~last_grant_q;
        end else begin
            grant_idx = elig1;
        end
    end

    assign op_hit      = is_op_code(s_addr_q[ADDR_W-1 -: 2], s_addr_q[3:0]);
    assign timer_clear = (state_q != ST_IDLE) || (lock_owner_q ? m1_stb_i : m0_stb_i);

    ai_lock_timer #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_timer (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_i),
        .lock_i   (lock_valid_q),
        .clear_i  (timer_clear),
        .expire_o (lock_expire)
    );

    // Arbitration FSM: grant in IDLE, wait for the accelerator in FWD, pulse the ack in RESP.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            s_addr_q     <= '0;
            s_we_q       <= 1'b0;
            s_data_q     <= '0;
            s_stb_q      <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_data_q    <= '0;
            m1_data_q    <= '0;
        end else begin
            if (lock_expire) begin
                lock_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    if (grant_valid) begin
                        s_addr_q     <= grant_idx ? m1_addr_i : m0_addr_i;
                        s_we_q       <= grant_idx ? m1_we_i   : m0_we_i;
                        s_data_q     <= grant_idx ? m1_data_i : m0_data_i;
                        s_stb_q      <= 1'b1;
                        last_grant_q <= grant_idx;
                        state_q      <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (s_ack_i) begin
                        s_stb_q <= 1'b0;
                        if (last_grant_q) begin
                            m1_ack_q  <= 1'b1;
                            m1_data_q <= s_data_i;
                        end else begin
                            m0_ack_q  <= 1'b1;
                            m0_data_q <= s_data_i;
                        end
                        if (s_we_q && op_hit) begin
                            if (!lock_valid_q) begin
                                lock_valid_q <= 1'b1;
                                lock_owner_q <= last_grant_q;
                            end else if ((lock_owner_q == last_grant_q) && (s_data_q == '0)) begin
                                lock_valid_q <= 1'b0;
                            end
                        end
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_addr_o     = s_addr_q;
    assign s_we_o       = s_we_q;
    assign s_data_o     = s_data_q;
    assign s_stb_o      = s_stb_q;
    assign m0_ack_o     = m0_ack_q;
    assign m1_ack_o     = m1_ack_q;
    assign m0_data_o    = m0_data_q;
    assign m1_data_o    = m1_data_q;
    assign lock_valid_o = lock_valid_q;
    assign lock_owner_o = lock_owner_q;

endmodule

// File: tb/tb_ai_accel_wb_arbiter.sv
// tb/tb_ai_accel_wb_arbiter.sv - scoreboard bench for ai_accel_wb_arbiter
module tb_ai_accel_wb_arbiter;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_we, m0_stb, m1_we, m1_stb;
    logic        m0_ack_o, m1_ack_o;
    logic [31:0] m0_data_o, m1_data_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_we_o, s_stb_o, s_ack_i;
    logic        lock_valid_o, lock_owner_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          slave_delay = 2;
    logic        slave_hold = 1'b0;
    logic [31:0] slave_rdata = 32'h1234_5678;
    int          stb_len = 0;
    int          last_len = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } fwd_t;

    fwd_t        exp_s_q[$];
    logic [31:0] exp_m0_q[$];
    logic [31:0] exp_m1_q[$];

    ai_accel_wb_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .LOCK_TIMEOUT (16)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (wb_rst_i),
        .m0_addr_i    (m0_addr),
        .m0_we_i      (m0_we),
        .m0_data_i    (m0_wdata),
        .m0_stb_i     (m0_stb),
        .m0_ack_o     (m0_ack_o),
        .m0_data_o    (m0_data_o),
        .m1_addr_i    (m1_addr),
        .m1_we_i      (m1_we),
        .m1_data_i    (m1_wdata),
        .m1_stb_i     (m1_stb),
        .m1_ack_o     (m1_ack_o),
        .m1_data_o    (m1_data_o),
        .s_addr_o     (s_addr_o),
        .s_we_o       (s_we_o),
        .s_data_o     (s_data_o),
        .s_stb_o      (s_stb_o),
        .s_ack_i      (s_ack_i),
        .s_data_i     (s_data_i),
        .lock_valid_o (lock_valid_o),
        .lock_owner_o (lock_owner_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic push_fwd(input logic [31:0] a, input logic w, input logic [31:0] d);
        fwd_t f;
        f.addr = a;
        f.we   = w;
        f.data = d;
        exp_s_q.push_back(f);
    endtask

    task automatic m_req(input int m, input logic [31:0] a, input logic w, input logic [31:0] d);
        if (m == 0) begin
            m0_addr = a; m0_we = w; m0_wdata = d; m0_stb = 1'b1;
        end else begin
            m1_addr = a; m1_we = w; m1_wdata = d; m1_stb = 1'b1;
        end
    endtask

    task automatic m_wait(input int m, input int budget, output int at_cyc);
        logic done;
        done   = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack_o : m1_ack_o) begin
                done   = 1'b1;
                at_cyc = cyc;
                if (m == 0) m0_stb = 1'b0; else m1_stb = 1'b0;
            end
        end
        if (!done) begin
            if (m == 0) m0_stb = 1'b0; else m1_stb = 1'b0;
        end
        check($sformatf("ack_within_budget_m%0d", m), {31'd0, done}, 32'd1);
    endtask

    // Accelerator model: acks after slave_delay strobe cycles unless held off.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        s_ack_i  = 1'b0;
        s_data_i = '0;
        forever begin
            @(negedge clk);
            if (s_stb_o && !s_ack_i && !slave_hold) begin
                if (wait_cnt == slave_delay) begin
                    s_ack_i  = 1'b1;
                    s_data_i = slave_rdata;
                    wait_cnt = 0;
                end else begin
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                s_ack_i = 1'b0;
                if (!s_stb_o) wait_cnt = 0;
            end
        end
    end

    // Monitor: checks every forwarded request and every master ack against the scoreboard.
    initial begin
        logic prev_stb, prev_a0, prev_a1;
        fwd_t f;
        logic [31:0] d;
        prev_stb = 1'b0; prev_a0 = 1'b0; prev_a1 = 1'b0;
        forever begin
            @(negedge clk);
            if (s_stb_o) begin
                stb_len = stb_len + 1;
            end else if (prev_stb) begin
                last_len = stb_len;
                stb_len  = 0;
            end
            if (s_stb_o && !prev_stb) begin
                if (exp_s_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL fwd_unexpected: got addr 0x%08h, none expected", s_addr_o);
                end else begin
                    f = exp_s_q.pop_front();
                    check("fwd_addr", s_addr_o, f.addr);
                    check("fwd_we", {31'd0, s_we_o}, {31'd0, f.we});
                    check("fwd_data", s_data_o, f.data);
                end
            end
            if (m0_ack_o) begin
                check("m0_ack_single_cycle", {31'd0, prev_a0}, 32'd0);
                if (exp_m0_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL m0_ack_unexpected: got data 0x%08h, none expected", m0_data_o);
                end else begin
                    d = exp_m0_q.pop_front();
                    check("m0_rdata", m0_data_o, d);
                end
            end
            if (m1_ack_o) begin
                check("m1_ack_single_cycle", {31'd0, prev_a1}, 32'd0);
                if (exp_m1_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL m1_ack_unexpected: got data 0x%08h, none expected", m1_data_o);
                end else begin
                    d = exp_m1_q.pop_front();
                    check("m1_rdata", m1_data_o, d);
                end
            end
            prev_stb = s_stb_o;
            prev_a0  = m0_ack_o;
            prev_a1  = m1_ack_o;
        end
    end

    // Directed stimulus.
    initial begin
        int t0, t1, n;
        logic dropped;
        wb_rst_i = 1'b0;
        m0_addr = '0; m0_we = 1'b0; m0_wdata = '0; m0_stb = 1'b0;
        m1_addr = '0; m1_we = 1'b0; m1_wdata = '0; m1_stb = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_stb", {31'd0, s_stb_o}, 32'd0);
        check("rst_s_addr", s_addr_o, 32'd0);
        check("rst_lock_valid", {31'd0, lock_valid_o}, 32'd0);
        check("rst_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
        wb_rst_i = 1'b1;
        @(negedge clk);

        // m0 operation write acquires the lock
        push_fwd(32'h0000_0000, 1'b1, 32'h1);
        exp_m0_q.push_back(32'h1234_5678);
        m_req(0, 32'h0000_0000, 1'b1, 32'h1);
        @(negedge clk);
        check("t1_stb_one_cycle_after", {31'd0, s_stb_o}, 32'd1);
        check("t1_s_data", s_data_o, 32'h1);
        m_wait(0, 50, t0);
        check("t1_lock_valid", {31'd0, lock_valid_o}, 32'd1);
        check("t1_lock_owner", {31'd0, lock_owner_o}, 32'd0);

        // m0 writes 0 to op register 0 -> lock released
        push_fwd(32'h0000_0000, 1'b1, 32'h0);
        exp_m0_q.push_back(32'h1234_5678);
        m_req(0, 32'h0000_0000, 1'b1, 32'h0);
        m_wait(0, 50, t0);
        check("rel_lock_valid", {31'd0, lock_valid_o}, 32'd0);

        // simultaneous strobes, last_grant=0 -> m1 first, m0 right after
        @(negedge clk);
        push_fwd(32'h4000_0010, 1'b1, 32'h0000_00A1);
        push_fwd(32'h8000_0020, 1'b0, 32'h0);
        exp_m1_q.push_back(32'h1234_5678);
        exp_m0_q.push_back(32'h1234_5678);
        m_req(0, 32'h8000_0020, 1'b0, 32'h0);
        m_req(1, 32'h4000_0010, 1'b1, 32'h0000_00A1);
        fork
            m_wait(0, 60, t0);
            m_wait(1, 60, t1);
        join
        check("t2_ack_spacing", t0 - t1, 32'd5);

        // locked by m0: m1 stalls until m0 releases
        push_fwd(32'h0000_0000, 1'b1, 32'h1);
        exp_m0_q.push_back(32'h1234_5678);
        m_req(0, 32'h0000_0000, 1'b1, 32'h1);
        m_wait(0, 50, t0);
        check("t3_lock_owner0", {30'd0, lock_valid_o, lock_owner_o}, 32'd2);
        m_req(1, 32'h4000_0000, 1'b1, 32'h55);
        repeat (8) @(negedge clk);
        check("t3_m1_stalled", {30'd0, s_stb_o, m1_ack_o}, 32'd0);
        push_fwd(32'h0000_0000, 1'b1, 32'h0);
        push_fwd(32'h4000_0000, 1'b1, 32'h55);
        exp_m0_q.push_back(32'h1234_5678);
        exp_m1_q.push_back(32'h1234_5678);
        m_req(0, 32'h0000_0000, 1'b1, 32'h0);
        m_wait(0, 50, t0);
        check("t3_released", {31'd0, lock_valid_o}, 32'd0);
        @(negedge clk);
        check("t3_idle_gap", {31'd0, s_stb_o}, 32'd0);
        @(negedge clk);
        check("t3_m1_forwarded", {31'd0, s_stb_o}, 32'd1);
        m_wait(1, 50, t1);

        // lock held by m1 expires after 16 idle cycles, pending m0 then granted
        push_fwd(32'h0000_0000, 1'b1, 32'h2);
        exp_m1_q.push_back(32'h1234_5678);
        m_req(1, 32'h0000_0000, 1'b1, 32'h2);
        m_wait(1, 50, t1);
        check("t4_lock_owner1", {30'd0, lock_valid_o, lock_owner_o}, 32'd3);
        push_fwd(32'h8000_0004, 1'b1, 32'h77);
        exp_m0_q.push_back(32'h1234_5678);
        m_req(0, 32'h8000_0004, 1'b1, 32'h77);
        n = 0;
        dropped = 1'b0;
        while (n < 100 && !dropped) begin
            @(negedge clk);
            n = n + 1;
            if (!lock_valid_o) dropped = 1'b1;
        end
        check("t4_timeout_cycles", n, 32'd17);
        check("t4_no_grant_at_release", {31'd0, s_stb_o}, 32'd0);
        m_wait(0, 50, t0);

        // long accelerator wait with read data
        slave_delay = 500;
        slave_rdata = 32'hDEAD_BEEF;
        push_fwd(32'hC000_0000, 1'b0, 32'h0);
        exp_m0_q.push_back(32'hDEAD_BEEF);
        m_req(0, 32'hC000_0000, 1'b0, 32'h0);
        m_wait(0, 600, t0);
        @(negedge clk);
        check("t5_stb_held_cycles", last_len, 32'd501);
        slave_delay = 2;
        slave_rdata = 32'h1234_5678;

        // reset while forwarding abandons the transaction
        slave_hold = 1'b1;
        push_fwd(32'h0000_0000, 1'b1, 32'h9);
        m_req(1, 32'h0000_0000, 1'b1, 32'h9);
        repeat (5) @(negedge clk);
        check("t6_in_fwd", {31'd0, s_stb_o}, 32'd1);
        wb_rst_i = 1'b0;
        @(negedge clk);
        check("t6_rst_stb", {31'd0, s_stb_o}, 32'd0);
        check("t6_rst_acks_lock", {29'd0, m1_ack_o, m0_ack_o, lock_valid_o}, 32'd0);
        m1_stb = 1'b0;
        slave_hold = 1'b0;
        @(negedge clk);
        wb_rst_i = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_after_rst", {31'd0, s_stb_o}, 32'd0);

        check("sb_fwd_drained", exp_s_q.size(), 32'd0);
        check("sb_m0_drained", exp_m0_q.size(), 32'd0);
        check("sb_m1_drained", exp_m1_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
